adder3_chain_sequencer: RTL and testbench
=========================================

// Module: adder3_chain_sequencer
// PURPOSE
//  Sequencer between an operand stream and the combinational 3-bit adder (pi0..pi6 -> po0..po3).
//  Splits DIGITS*3-bit operands into 3-bit digits and drives them into the adder LSB digit first.
//  Chains the adder carry between digits, assembles the wide sum and returns it on a valid/ready handshake.
//  Lets the fixed 3-bit adder netlist, or any evolved replacement, compute arbitrarily wide sums.
// PARAMETERS
//  DIGITS         4  number of 3-bit digits per operand, >=1; WIDTH = 3*DIGITS
//  SETTLE_CYCLES  1  cycles each digit is held on pi* before po* is sampled, >=1
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  in_valid  in   1      operand pair valid
//  in_ready  out  1      sequencer can accept operands
//  in_a      in   WIDTH  operand A
//  in_b      in   WIDTH  operand B
//  in_cin    in   1      carry into digit 0
//  pi0..pi6  out  1 each adder inputs: A digit = {pi0,pi1,pi4}, B digit = {pi2,pi3,pi5}, cin = pi6
//  po0..po3  in   1 each adder outputs: cout = po0, sum digit = {po1,po2,po3}
//  out_valid out  1      result valid
//  out_ready in   1      consumer accepts result
//  out_sum   out  WIDTH  assembled sum
//  out_cout  out  1      carry out of the top digit
//  busy      out  1      high in ISSUE or DONE
// BEHAVIOUR
//  - Reset, asynchronous: state=IDLE; in_ready, out_valid, out_cout, busy, all pi*, out_sum = 0.
//    in_ready is registered and rises on the first clk edge after rst_n deasserts.
//  - FSM states IDLE, ISSUE and DONE:
//    IDLE:  in_ready=1. On in_valid&in_ready, register a, b and cin; clear digit index, settle count and
//           result register; go to ISSUE. in_ready drops on that same edge.
//    ISSUE: pi* are driven from registered digit[idx] of A and B and the carry register.
//           Hold for SETTLE_CYCLES cycles. On the last settle cycle, at the clock edge:
//           write {po1,po2,po3} into out_sum[3*idx+:3] and po0 into the carry register.
//           If idx==DIGITS-1, go to DONE and load out_cout=po0. Otherwise increment idx.
//    DONE:  out_valid=1; out_sum and out_cout are held stable. On out_ready, go to IDLE.
//           out_valid drops and in_ready rises on that same edge.
//  - pi* are registered. They equal 0 in IDLE and DONE, and change only on digit boundaries.
//  - Latency: out_valid is first high in the cycle after edge number DIGITS*SETTLE_CYCLES,
//    counted from the accepting edge.
//  - Throughput: one transaction per DIGITS*SETTLE_CYCLES+2 cycles. There is no overlap and no input buffering.
//  - Boundaries:
//    in_valid during ISSUE/DONE is ignored, since in_ready=0.
//    out_ready high before DONE has no effect.
//    DIGITS=1 is a single ISSUE pass.
//    Carry into digit 0 is in_cin; carry ripples to a final cout with no truncation.
//    rst_n asserted mid-ISSUE or mid-DONE aborts immediately to reset values. The partial result is discarded.
//  - Sum semantics: {out_cout,out_sum} = in_a + in_b + in_cin, as an unsigned sum of WIDTH+1 bits.
// CONFIGURATION
//  ADDER3_CHAIN_SUB_EN defined:
//   - Adds port in_sub (in, 1), captured with the operands.
//   - in_sub=1: B digits are driven inverted onto pi2/pi3/pi5, the initial carry is 1 and in_cin is ignored.
//     Result: out_sum = in_a - in_b mod 2^WIDTH; out_cout = 1 means no borrow.
//   - in_sub=0: addition exactly as above.
//  ADDER3_CHAIN_SUB_EN undefined:
//   - No in_sub port; addition only.
// TESTING  (DIGITS=4, SETTLE_CYCLES=1 unless noted)
//  1. a=0x123, b=0x456, cin=0
//     -> out_sum=0x579, out_cout=0; out_valid first high the cycle after the 4th edge past accept.
//  2. a=0xFFF, b=0x001, cin=0
//     -> full ripple; digits 1..3 each see pi6=1; out_sum=0x000, out_cout=1.
//  3. a=0xFFF, b=0xFFF, cin=1 -> out_sum=0xFFF, out_cout=1. Repeat with SETTLE_CYCLES=3:
//     each pi* digit is held 3 cycles; same result 12 edges after accept.
//  4. Result 0x579 with out_ready held low 5 cycles
//     -> out_valid, out_sum and out_cout stable; in_ready=0; pi*=0; in_ready rises on the out_ready edge.
//  5. rst_n pulsed low while digit 2 is being issued
//     -> all outputs 0 asynchronously; after release, a=0x007, b=0x001 -> out_sum=0x008, out_cout=0.
//  6. ADDER3_CHAIN_SUB_EN: a=0x005, b=0x007, in_sub=1 -> out_sum=0xFFE, out_cout=0.
//     a=0x007, b=0x005 -> out_sum=0x002, out_cout=1.

Source files
------------

// File: rtl/adder3_chain_sequencer_if.sv
// Operand/result valid-ready bundle for adder3_chain_sequencer.
// ADDER3_CHAIN_SUB_EN adds in_sub to the operand side.
interface adder3_chain_sequencer_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef ADDER3_CHAIN_SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

`ifdef ADDER3_CHAIN_SUB_EN
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
`endif
endinterface

// File: rtl/adder3_chain_sequencer.sv
// Feeds a 3-bit combinational adder digit by digit, rippling carry.
// ADDER3_CHAIN_SUB_EN adds subtraction (invert B, carry-in 1).
module adder3_chain_sequencer #(
    parameter int DIGITS        = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    adder3_chain_sequencer_if.slave  bus,
    output logic                     pi0,
    output logic                     pi1,
    output logic                     pi2,
    output logic                     pi3,
    output logic                     pi4,
    output logic                     pi5,
    output logic                     pi6,
    input  logic                     po0,
    input  logic                     po1,
    input  logic                     po2,
    input  logic                     po3,
    output logic                     busy
);
    localparam int WIDTH = 3 * DIGITS;
    localparam int IDXW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SETW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);
    localparam logic [SETW-1:0] LAST_SET = SETW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_in_ready, w_in_ready_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [WIDTH-1:0] r_sum, w_sum_nxt;
    logic             r_cout, w_cout_nxt;
    logic [IDXW-1:0]  r_idx, w_idx_nxt;
    logic [SETW-1:0]  r_settle, w_settle_nxt;
    logic [6:0]       r_pi, w_pi_nxt;

    logic             w_accept;
    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [2:0]       w_po_sum;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;

    // Bit k of the result is pin pik; r_pi[6] doubles as the carry register.
    function automatic logic [6:0] pack_pi(
        input logic [2:0] a,
        input logic [2:0] b,
        input logic       c
    );
        return {c, b[0], a[0], b[1], b[2], a[1], a[2]};
    endfunction

`ifdef ADDER3_CHAIN_SUB_EN
    assign w_sub = bus.in_sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_b_eff   = w_sub ? ~bus.in_b : bus.in_b;
    assign w_cin_eff = w_sub | bus.in_cin;
    assign w_accept  = (r_state == S_IDLE) & r_in_ready & bus.in_valid;
    assign w_po_sum  = {po1, po2, po3};
    assign w_a_sh    = r_a >> 3;
    assign w_b_sh    = r_b >> 3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_idx      <= '0;
            r_settle   <= '0;
            r_pi       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_sum      <= w_sum_nxt;
            r_cout     <= w_cout_nxt;
            r_idx      <= w_idx_nxt;
            r_settle   <= w_settle_nxt;
            r_pi       <= w_pi_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_in_ready_nxt = r_in_ready;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_sum_nxt      = r_sum;
        w_cout_nxt     = r_cout;
        w_idx_nxt      = r_idx;
        w_settle_nxt   = r_settle;
        w_pi_nxt       = r_pi;
        unique case (r_state)
            S_IDLE: begin
                w_in_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt    = S_ISSUE;
                    w_in_ready_nxt = 1'b0;
                    w_a_nxt        = bus.in_a;
                    w_b_nxt        = w_b_eff;
                    w_sum_nxt      = '0;
                    w_cout_nxt     = 1'b0;
                    w_idx_nxt      = '0;
                    w_settle_nxt   = '0;
                    w_pi_nxt       = pack_pi(bus.in_a[2:0], w_b_eff[2:0],
                                             w_cin_eff);
                end
            end
            S_ISSUE: begin
                if (r_settle == LAST_SET) begin
                    w_settle_nxt = '0;
                    for (int d = 0; d < DIGITS; d++) begin
                        if (r_idx == IDXW'(d)) begin
                            w_sum_nxt[3*d +: 3] = w_po_sum;
                        end
                    end
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                        w_cout_nxt  = po0;
                        w_pi_nxt    = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                        w_a_nxt   = w_a_sh;
                        w_b_nxt   = w_b_sh;
                        w_pi_nxt  = pack_pi(w_a_sh[2:0], w_b_sh[2:0], po0);
                    end
                end else begin
                    w_settle_nxt = r_settle + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt    = S_IDLE;
                    w_in_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign busy          = (r_state != S_IDLE);

    assign pi0 = r_pi[0];
    assign pi1 = r_pi[1];
    assign pi2 = r_pi[2];
    assign pi3 = r_pi[3];
    assign pi4 = r_pi[4];
    assign pi5 = r_pi[5];
    assign pi6 = r_pi[6];
endmodule

// File: tb/tb_adder3_chain_sequencer.sv
// Scoreboard bench: sequencers with SETTLE_CYCLES 1 and 3 share stimulus,
// each driving a behavioural 3-bit adder on its pi/po pins.
module tb_adder3_chain_sequencer;
    localparam int D = 4;
    localparam int W = 3 * D;
    localparam int SET [2] = '{1, 3};

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic [W-1:0] a;
        logic [W-1:0] bb;
        logic         c0;
        int           acc;
        int           stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic iv = 1'b0;
    logic [W-1:0] ia = '0;
    logic [W-1:0] ib = '0;
    logic ic = 1'b0;
    logic ordy [2] = '{1'b0, 1'b0};

    adder3_chain_sequencer_if #(.WIDTH(W)) bus0 ();
    adder3_chain_sequencer_if #(.WIDTH(W)) bus1 ();

    assign bus0.in_valid  = iv;
    assign bus0.in_a      = ia;
    assign bus0.in_b      = ib;
    assign bus0.in_cin    = ic;
    assign bus0.out_ready = ordy[0];
    assign bus1.in_valid  = iv;
    assign bus1.in_a      = ia;
    assign bus1.in_b      = ib;
    assign bus1.in_cin    = ic;
    assign bus1.out_ready = ordy[1];
`ifdef ADDER3_CHAIN_SUB_EN
    logic isub = 1'b0;
    assign bus0.in_sub = isub;
    assign bus1.in_sub = isub;
`endif

    wire [6:0]   pi_w [2];
    wire [3:0]   po_w [2];
    wire         bz [2];
    wire         ov [2];
    wire         ir [2];
    wire         oc [2];
    wire [W-1:0] os [2];

    // Reference 3-bit adder: A={pi0,pi1,pi4}, B={pi2,pi3,pi5}, cin=pi6.
    function automatic logic [3:0] add3(input logic [6:0] p);
        logic [3:0] s;
        s = {1'b0, p[0], p[1], p[4]} + {1'b0, p[2], p[3], p[5]}
            + {3'b0, p[6]};
        return {s[0], s[1], s[2], s[3]};
    endfunction

    assign po_w[0] = add3(pi_w[0]);
    assign po_w[1] = add3(pi_w[1]);
    assign ov[0] = bus0.out_valid;
    assign ov[1] = bus1.out_valid;
    assign ir[0] = bus0.in_ready;
    assign ir[1] = bus1.in_ready;
    assign oc[0] = bus0.out_cout;
    assign oc[1] = bus1.out_cout;
    assign os[0] = bus0.out_sum;
    assign os[1] = bus1.out_sum;

    adder3_chain_sequencer #(.DIGITS(D), .SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .pi0(pi_w[0][0]), .pi1(pi_w[0][1]), .pi2(pi_w[0][2]),
        .pi3(pi_w[0][3]), .pi4(pi_w[0][4]), .pi5(pi_w[0][5]),
        .pi6(pi_w[0][6]),
        .po0(po_w[0][0]), .po1(po_w[0][1]), .po2(po_w[0][2]),
        .po3(po_w[0][3]),
        .busy(bz[0])
    );

    adder3_chain_sequencer #(.DIGITS(D), .SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .pi0(pi_w[1][0]), .pi1(pi_w[1][1]), .pi2(pi_w[1][2]),
        .pi3(pi_w[1][3]), .pi4(pi_w[1][4]), .pi5(pi_w[1][5]),
        .pi6(pi_w[1][6]),
        .po0(po_w[1][0]), .po1(po_w[1][1]), .po2(po_w[1][2]),
        .po3(po_w[1][3]),
        .busy(bz[1])
    );

    exp_t sb [2][$];
    int held [2] = '{0, 0};
    logic seen [2] = '{1'b0, 1'b0};
    logic rdy_chk [2] = '{1'b0, 1'b0};
    logic [6:0] trace [2][$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s,
                                   input int stall);
        exp_t e;
        logic [W:0] full;
        e.a = a;
        e.bb = s ? ~b : b;
        e.c0 = s | c;
        if (s) begin
            full = {1'b0, a} - {1'b0, b};
            e.sum = full[W-1:0];
            e.cout = (a >= b);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            e.sum = full[W-1:0];
            e.cout = full[W];
        end
        e.acc = 0;
        e.stall = stall;
        return e;
    endfunction

    // Pins expected while digit d is issued; its carry-in comes from the
    // plain sum of all lower digits.
    function automatic logic [6:0] exp_pi(input exp_t e, input int d);
        logic [W-1:0] m;
        logic [W:0] low;
        logic [W-1:0] ash;
        logic [W-1:0] bsh;
        logic [6:0] p;
        m = (W'(1) << (3 * d)) - W'(1);
        low = {1'b0, e.a & m} + {1'b0, e.bb & m} + {{W{1'b0}}, e.c0};
        ash = e.a >> (3 * d);
        bsh = e.bb >> (3 * d);
        p[0] = ash[2];
        p[1] = ash[1];
        p[4] = ash[0];
        p[2] = bsh[2];
        p[3] = bsh[1];
        p[5] = bsh[0];
        p[6] = low[3*d];
        return p;
    endfunction

    task automatic mon_step(input int k);
        exp_t e;
        if (rdy_chk[k]) begin
            chk($sformatf("in_ready_after_take%0d", k), ir[k], 1);
            rdy_chk[k] = 1'b0;
        end
        if (bz[k] && !ov[k]) trace[k].push_back(pi_w[k]);
        if (!ov[k]) begin
            ordy[k] = 1'($urandom_range(0, 1));
            return;
        end
        if (sb[k].size() == 0) begin
            chk($sformatf("spurious_valid%0d", k), sb[k].size(), 1);
            ordy[k] = 1'b1;
            return;
        end
        e = sb[k][0];
        if (!seen[k]) begin
            seen[k] = 1'b1;
            chk($sformatf("latency%0d", k), cyc - e.acc, D * SET[k]);
            chk($sformatf("trace_len%0d", k), trace[k].size(), D * SET[k]);
            foreach (trace[k][j]) begin
                if (j < D * SET[k])
                    chk($sformatf("pins%0d_c%0d", k, j), trace[k][j],
                        exp_pi(e, j / SET[k]));
            end
        end
        chk($sformatf("sum%0d", k), os[k], e.sum);
        chk($sformatf("cout%0d", k), oc[k], e.cout);
        chk($sformatf("in_ready_done%0d", k), ir[k], 0);
        chk($sformatf("pins_done%0d", k), pi_w[k], 0);
        chk($sformatf("busy_done%0d", k), bz[k], 1);
        ordy[k] = (held[k] >= e.stall);
        if (ordy[k]) begin
            void'(sb[k].pop_front());
            held[k] = 0;
            seen[k] = 1'b0;
            trace[k].delete();
            rdy_chk[k] = 1'b1;
        end else begin
            held[k]++;
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                held[k] = 0;
                seen[k] = 1'b0;
                rdy_chk[k] = 1'b0;
                trace[k].delete();
                ordy[k] = 1'b0;
            end else begin
                mon_step(k);
            end
        end
    end

    task automatic finish_now();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic chk_zero(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_in_ready%0d", nm, k), ir[k], 0);
            chk($sformatf("%s_out_valid%0d", nm, k), ov[k], 0);
            chk($sformatf("%s_cout%0d", nm, k), oc[k], 0);
            chk($sformatf("%s_busy%0d", nm, k), bz[k], 0);
            chk($sformatf("%s_sum%0d", nm, k), os[k], 0);
            chk($sformatf("%s_pins%0d", nm, k), pi_w[k], 0);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input int stall);
        exp_t e;
        int t;
        t = 0;
        while (!(ir[0] && ir[1])) begin
            iv = (!ir[0] && !ir[1]) ? 1'($urandom_range(0, 1)) : 1'b0;
            ia = W'($urandom);
            ib = W'($urandom);
            ic = 1'($urandom_range(0, 1));
            @(negedge clk);
            t++;
            if (t > 500) begin
                chk("ready_timeout", t, 0);
                finish_now();
            end
        end
        ia = a;
        ib = b;
        ic = c;
`ifdef ADDER3_CHAIN_SUB_EN
        isub = s;
`endif
        iv = 1'b1;
        e = model(a, b, c, s, stall);
        e.acc = cyc + 1;
        sb[0].push_back(e);
        sb[1].push_back(e);
        @(negedge clk);
        iv = 1'b0;
    endtask

    initial begin
        int t;
        logic s;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("in_ready_pre_edge", ir[0], 0);
        @(negedge clk);
        chk("in_ready_post_edge0", ir[0], 1);
        chk("in_ready_post_edge1", ir[1], 1);

        send(12'h123, 12'h456, 1'b0, 1'b0, 0);
        send(12'hFFF, 12'h001, 1'b0, 1'b0, 1);
        send(12'hFFF, 12'hFFF, 1'b1, 1'b0, 0);
        send(12'h123, 12'h456, 1'b0, 1'b0, 5);

        send(12'h321, 12'h654, 1'b1, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("digit2_on_pins", pi_w[0], exp_pi(sb[0][0], 2));
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        sb[0].delete();
        sb[1].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(12'h007, 12'h001, 1'b0, 1'b0, 0);

`ifdef ADDER3_CHAIN_SUB_EN
        send(12'h005, 12'h007, 1'b0, 1'b1, 0);
        send(12'h007, 12'h005, 1'b1, 1'b1, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            s = 1'b0;
`ifdef ADDER3_CHAIN_SUB_EN
            s = 1'($urandom_range(0, 1));
`endif
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), s,
                 int'($urandom_range(0, 2)));
        end

        t = 0;
        while (sb[0].size() != 0 || sb[1].size() != 0) begin
            @(negedge clk);
            t++;
            if (t > 2000) begin
                chk("drain_timeout", sb[0].size() + sb[1].size(), 0);
                break;
            end
        end
        repeat (2) @(negedge clk);
        finish_now();
    end
endmodule
